// File: rtl/inst_fetch_buffer_pkg.sv
// Shared constants and entry type for the instruction fetch buffer.
// Widths follow the existing InstBus / InstAddrBus (32-bit) definitions.
package inst_fetch_buffer_pkg;

  localparam int INST_BUS_W     = 32;
  localparam int INST_ADDR_BUS_W = 32;

  localparam int IBUF_DEPTH = 16;
  localparam int IBUF_PTR_W = 4;

  // One queue slot: fetched word plus the address it came from.
  typedef struct packed {
    logic [INST_BUS_W-1:0]      inst;
    logic [INST_ADDR_BUS_W-1:0] addr;
  } ibuf_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_ptr_ctrl.sv
// Pointer/count bookkeeping for the fetch buffer: decides how many entries
// are pushed and popped each cycle and keeps head, tail and count.
module ibuf_ptr_ctrl
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int PTR_W = IBUF_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inst1_valid,
  input  logic             inst2_valid,
  input  logic             issue,
  input  logic             issue_mode,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [PTR_W:0]   count,
  output logic [1:0]       push_amt,
  output logic [1:0]       pop_amt,
  output logic             full,
  output logic             valid1,
  output logic             valid2
);

  // Fewer than two free slots stalls fetch, even for a lone instruction.
  localparam logic [PTR_W:0] FULL_THR = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [PTR_W:0]   count_reg, count_next;

  assign full   = (count_reg >= FULL_THR);
  assign valid1 = (count_reg >= CNT_ONE);
  assign valid2 = (count_reg >= CNT_TWO);
  assign head   = head_reg;
  assign tail   = tail_reg;
  assign count  = count_reg;

  // Push amount: uses pre-pop occupancy; inst2 alone is meaningless.
  always_comb begin
    push_amt = 2'd0;
    if (!flush && !full && inst1_valid)
      push_amt = inst2_valid ? 2'd2 : 2'd1;
  end

  // Pop amount: a dual request with one entry degrades to a single pop.
  always_comb begin
    pop_amt = 2'd0;
    if (issue && !flush) begin
      if (issue_mode && valid2)
        pop_amt = 2'd2;
      else if (valid1)
        pop_amt = 2'd1;
    end
  end

  // Next-state pointers; flush empties the queue and overrides push/pop.
  always_comb begin
    head_next  = head_reg + PTR_W'(pop_amt);
    tail_next  = tail_reg + PTR_W'(push_amt);
    count_next = count_reg + (PTR_W+1)'(push_amt) - (PTR_W+1)'(pop_amt);
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  // Pointer and count registers; reset beats flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Dual-write / dual-read circular instruction queue between fetch and decode.
// Optional macro IBUF_PERF_EN adds full-stall and empty-starve cycle counters.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH  = IBUF_DEPTH,
  parameter int PTR_W  = IBUF_PTR_W,
  parameter int INST_W = INST_BUS_W,
  parameter int ADDR_W = INST_ADDR_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [INST_W-1:0] fetch_inst1_i,
  input  logic [INST_W-1:0] fetch_inst2_i,
  input  logic [ADDR_W-1:0] fetch_addr1_i,
  input  logic [ADDR_W-1:0] fetch_addr2_i,
  input  logic              fetch_inst1_valid_i,
  input  logic              fetch_inst2_valid_i,
  output logic              buffer_full_o,
  input  logic              issue_i,
  input  logic              issue_mode_i,
  output logic [INST_W-1:0] issue_inst1_o,
  output logic [INST_W-1:0] issue_inst2_o,
  output logic [ADDR_W-1:0] issue_addr1_o,
  output logic [ADDR_W-1:0] issue_addr2_o,
  output logic              issue_inst1_valid_o,
  output logic              issue_inst2_valid_o,
  output logic [PTR_W:0]    occupancy_o
`ifdef IBUF_PERF_EN
  ,
  output logic [31:0]       perf_full_cycles_o,
  output logic [31:0]       perf_empty_cycles_o
`endif
);

  logic [INST_W-1:0] inst_mem_reg [DEPTH];
  logic [ADDR_W-1:0] addr_mem_reg [DEPTH];

  logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
  logic [PTR_W:0]   count;
  logic [1:0]       push_amt, pop_amt;
  logic             full, valid1, valid2;
  logic             we1, we2;

  ibuf_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_ctrl (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush_i),
    .inst1_valid (fetch_inst1_valid_i),
    .inst2_valid (fetch_inst2_valid_i),
    .issue       (issue_i),
    .issue_mode  (issue_mode_i),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .push_amt    (push_amt),
    .pop_amt     (pop_amt),
    .full        (full),
    .valid1      (valid1),
    .valid2      (valid2)
  );

  // Power-of-two depth: plain PTR_W-bit addition wraps for free.
  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);
  assign we1     = (push_amt != 2'd0);
  assign we2     = (push_amt == 2'd2);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Slot write: inst1 lands at tail, inst2 at tail+1.
      always_ff @(posedge clk) begin
        if (we1 && (tail == PTR_W'(gi))) begin
          inst_mem_reg[gi] <= fetch_inst1_i;
          addr_mem_reg[gi] <= fetch_addr1_i;
        end else if (we2 && (tail_p1 == PTR_W'(gi))) begin
          inst_mem_reg[gi] <= fetch_inst2_i;
          addr_mem_reg[gi] <= fetch_addr2_i;
        end
      end
    end
  endgenerate

  // Read side: combinational from head/head+1, zeroed when not valid.
  always_comb begin
    issue_inst1_o = '0;
    issue_addr1_o = '0;
    issue_inst2_o = '0;
    issue_addr2_o = '0;
    if (valid1) begin
      issue_inst1_o = inst_mem_reg[head];
      issue_addr1_o = addr_mem_reg[head];
    end
    if (valid2) begin
      issue_inst2_o = inst_mem_reg[head_p1];
      issue_addr2_o = addr_mem_reg[head_p1];
    end
  end

  assign buffer_full_o       = full;
  assign issue_inst1_valid_o = valid1;
  assign issue_inst2_valid_o = valid2;
  assign occupancy_o         = count;

`ifdef IBUF_PERF_EN
  logic [31:0] perf_full_reg, perf_empty_reg;

  // Saturating stall/starve counters; only reset clears them, not flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_reg  <= '0;
      perf_empty_reg <= '0;
    end else begin
      if (full && fetch_inst1_valid_i && (perf_full_reg != 32'hFFFF_FFFF))
        perf_full_reg <= perf_full_reg + 32'd1;
      if ((count == '0) && issue_i && (perf_empty_reg != 32'hFFFF_FFFF))
        perf_empty_reg <= perf_empty_reg + 32'd1;
    end
  end

  assign perf_full_cycles_o  = perf_full_reg;
  assign perf_empty_cycles_o = perf_empty_reg;
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed self-checking bench for inst_fetch_buffer.
module tb_inst_fetch_buffer;
  import inst_fetch_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush_i;
  logic [31:0] fetch_inst1_i, fetch_inst2_i, fetch_addr1_i, fetch_addr2_i;
  logic        fetch_inst1_valid_i, fetch_inst2_valid_i;
  logic        buffer_full_o, issue_i, issue_mode_i;
  logic [31:0] issue_inst1_o, issue_inst2_o, issue_addr1_o, issue_addr2_o;
  logic        issue_inst1_valid_o, issue_inst2_valid_o;
  logic [4:0]  occupancy_o;
`ifdef IBUF_PERF_EN
  logic [31:0] perf_full_cycles_o, perf_empty_cycles_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  inst_fetch_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_i             (flush_i),
    .fetch_inst1_i       (fetch_inst1_i),
    .fetch_inst2_i       (fetch_inst2_i),
    .fetch_addr1_i       (fetch_addr1_i),
    .fetch_addr2_i       (fetch_addr2_i),
    .fetch_inst1_valid_i (fetch_inst1_valid_i),
    .fetch_inst2_valid_i (fetch_inst2_valid_i),
    .buffer_full_o       (buffer_full_o),
    .issue_i             (issue_i),
    .issue_mode_i        (issue_mode_i),
    .issue_inst1_o       (issue_inst1_o),
    .issue_inst2_o       (issue_inst2_o),
    .issue_addr1_o       (issue_addr1_o),
    .issue_addr2_o       (issue_addr2_o),
    .issue_inst1_valid_o (issue_inst1_valid_o),
    .issue_inst2_valid_o (issue_inst2_valid_o),
    .occupancy_o         (occupancy_o)
`ifdef IBUF_PERF_EN
    ,
    .perf_full_cycles_o  (perf_full_cycles_o),
    .perf_empty_cycles_o (perf_empty_cycles_o)
`endif
  );

  // Instruction word tied to its address so order errors are visible.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs, then inputs return to idle.
  task automatic cyc(input logic v1, input logic v2, input logic [31:0] a1,
                     input logic [31:0] a2, input logic iss, input logic md,
                     input logic fl);
    ibuf_entry_t e1, e2;
    e1.addr = a1; e1.inst = inst_of(a1);
    e2.addr = a2; e2.inst = inst_of(a2);
    fetch_inst1_valid_i = v1;
    fetch_inst2_valid_i = v2;
    fetch_addr1_i = e1.addr; fetch_inst1_i = e1.inst;
    fetch_addr2_i = e2.addr; fetch_inst2_i = e2.inst;
    issue_i = iss; issue_mode_i = md; flush_i = fl;
    @(posedge clk); #1;
    $display("[TB] cyc v1=%0b v2=%0b a1=%h a2=%h iss=%0b md=%0b fl=%0b -> occ=%0d full=%0b",
             v1, v2, a1, a2, iss, md, fl, occupancy_o, buffer_full_o);
    fetch_inst1_valid_i = 1'b0; fetch_inst2_valid_i = 1'b0;
    issue_i = 1'b0; issue_mode_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush_i = 0; issue_i = 0; issue_mode_i = 0;
    fetch_inst1_valid_i = 0; fetch_inst2_valid_i = 0;
    fetch_inst1_i = 0; fetch_inst2_i = 0; fetch_addr1_i = 0; fetch_addr2_i = 0;
    do_reset();

    // Reset state
    check("rst_occ",  occupancy_o, 0);
    check("rst_full", buffer_full_o, 0);
    check("rst_v1",   issue_inst1_valid_o, 0);
    check("rst_v2",   issue_inst2_valid_o, 0);
    check("rst_inst1", issue_inst1_o, 0);

    // Eight dual pushes fill all 16 entries
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1, 32'h1000 + 8*k, 32'h1004 + 8*k, 0, 0, 0);
      check("fill_occ", occupancy_o, 2*(k+1));
      check("fill_full", buffer_full_o, (k == 7) ? 1 : 0);
    end
    cyc(1, 1, 32'h5000, 32'h5004, 0, 0, 0);
    check("full_block_occ", occupancy_o, 16);
    check("full_head_a1", issue_addr1_o, 32'h1000);
    check("full_head_a2", issue_addr2_o, 32'h1004);
    check("full_head_i2", issue_inst2_o, inst_of(32'h1004));

    // Single pop, then drain to occupancy 10
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("single_pop_occ", occupancy_o, 15);
    check("single_pop_full", buffer_full_o, 1);
    check("single_pop_a1", issue_addr1_o, 32'h1004);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("dual_pop_full", buffer_full_o, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("occ10", occupancy_o, 10);
    check("occ10_a1", issue_addr1_o, 32'h1018);

    // Flush with simultaneous push and issue
    cyc(1, 1, 32'h7000, 32'h7004, 1, 1, 1);
    check("flush_occ", occupancy_o, 0);
    check("flush_v1", issue_inst1_valid_o, 0);
    check("flush_v2", issue_inst2_valid_o, 0);
    check("flush_a1", issue_addr1_o, 0);

    // inst2_valid without inst1_valid is ignored
    cyc(0, 1, 32'h7100, 32'h7104, 0, 0, 0);
    check("inst2_only_occ", occupancy_o, 0);

    // Fill 3, then dual issue twice
    cyc(1, 1, 32'h1000, 32'h1004, 0, 0, 0);
    cyc(1, 0, 32'h1008, 32'h0, 0, 0, 0);
    check("fill3_occ", occupancy_o, 3);
    check("fill3_a1", issue_addr1_o, 32'h1000);
    check("fill3_a2", issue_addr2_o, 32'h1004);
    check("fill3_v2", issue_inst2_valid_o, 1);
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("iss1_occ", occupancy_o, 1);
    check("iss1_a1", issue_addr1_o, 32'h1008);
    check("iss1_v2", issue_inst2_valid_o, 0);
    check("iss1_a2_masked", issue_addr2_o, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("iss2_occ", occupancy_o, 0);
    check("iss2_v1", issue_inst1_valid_o, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("issue_empty_occ", occupancy_o, 0);

    // Walk head to index 15: head=tail=3 now; 7 dual pushes, 6 dual pops
    for (int k = 0; k < 7; k++)
      cyc(1, 1, 32'h2000 + 8*k, 32'h2004 + 8*k, 0, 0, 0);
    check("wrap_fill_occ", occupancy_o, 14);
    for (int k = 0; k < 6; k++)
      cyc(0, 0, 0, 0, 1, 1, 0);
    check("wrap_pre_occ", occupancy_o, 2);
    check("wrap_pre_a1", issue_addr1_o, 32'h2030);
    check("wrap_pre_a2", issue_addr2_o, 32'h2034);
    cyc(1, 1, 32'h3000, 32'h3004, 1, 1, 0);
    check("wrap_occ", occupancy_o, 2);
    check("wrap_a1", issue_addr1_o, 32'h3000);
    check("wrap_a2", issue_addr2_o, 32'h3004);
    check("wrap_i1", issue_inst1_o, inst_of(32'h3000));

    // Reset mid-operation overrides a push
    fetch_inst1_valid_i = 1; fetch_inst2_valid_i = 1; rst = 1;
    @(posedge clk); #1;
    rst = 0; fetch_inst1_valid_i = 0; fetch_inst2_valid_i = 0;
    check("midrst_occ", occupancy_o, 0);
    check("midrst_v1", issue_inst1_valid_o, 0);

`ifdef IBUF_PERF_EN
    do_reset();
    check("perf_rst_full", perf_full_cycles_o, 0);
    for (int k = 0; k < 8; k++)
      cyc(1, 1, 32'h1000 + 8*k, 32'h1004 + 8*k, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      cyc(1, 0, 32'h9000, 32'h0, 0, 0, 0);
    check("perf_full5", perf_full_cycles_o, 5);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 0, 0, 1, 1, 0);
    check("perf_empty3", perf_empty_cycles_o, 3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("perf_flush_full", perf_full_cycles_o, 5);
    check("perf_flush_empty", perf_empty_cycles_o, 3);
    do_reset();
    check("perf_clr_full", perf_full_cycles_o, 0);
    check("perf_clr_empty", perf_empty_cycles_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Dual-write, dual-read circular instruction queue between the cache/fetch stage and decode.
- Accepts up to two fetched instructions per cycle (inst1/inst2 with their addresses and valids) and presents up to two instructions per cycle to the dual-issue decoder.
- Decouples ICache hit/miss timing from issue, and raises a back-pressure stall to the fetch stage when it cannot accept a full pair.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- PTR_W, 4, pointer width; equals log2(DEPTH).
- INST_W, 32, instruction word width.
- ADDR_W, 32, instruction address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush_i  in  1  pipeline flush (branch mispredict or exception); discards all contents.
- fetch_inst1_i  in  INST_W  first fetched instruction.
- fetch_inst2_i  in  INST_W  second fetched instruction.
- fetch_addr1_i  in  ADDR_W  address of inst1.
- fetch_addr2_i  in  ADDR_W  address of inst2.
- fetch_inst1_valid_i  in  1  inst1 present.
- fetch_inst2_valid_i  in  1  inst2 present; honoured only when inst1_valid=1.
- buffer_full_o  out  1  stall to fetch/PC: free entries < 2.
- issue_i  in  1  decode consumes this cycle.
- issue_mode_i  in  1  1 = dual issue requested, 0 = single.
- issue_inst1_o  out  INST_W  instruction at head.
- issue_inst2_o  out  INST_W  instruction at head+1.
- issue_addr1_o  out  ADDR_W  address at head.
- issue_addr2_o  out  ADDR_W  address at head+1.
- issue_inst1_valid_o  out  1  count >= 1.
- issue_inst2_valid_o  out  1  count >= 2.
- occupancy_o  out  PTR_W+1  current entry count.

Behaviour:
- Storage: register array of {inst, addr}. head, tail are PTR_W bits and wrap modulo DEPTH. count is PTR_W+1 bits, range 0..DEPTH.
- Reset: head, tail and count = 0; all valids = 0; buffer_full_o = 0; data outputs 0 while empty (masked by valid).
- Read side is combinational from head and head+1 (zero added latency). Data outputs are zero when the corresponding valid is 0.
- Push amount:
  - 0 if flush_i, buffer_full_o, or inst1_valid = 0.
  - 2 if inst1_valid and inst2_valid.
  - 1 if inst1_valid only.
  - inst2_valid without inst1_valid is ignored.
- Write placement: inst1 goes to tail, inst2 to tail+1 (wrap). tail advances by the push amount.
- Pop amount:
  - 0 if !issue_i or flush_i.
  - 2 if issue_mode_i and count >= 2.
  - 1 if count >= 1.
  - 0 otherwise.
  - Dual request with count = 1 pops 1. Issue on empty pops nothing and is not an error.
- head advances by the pop amount. count_next = count + push - pop. Simultaneous push and pop on the same cycle is legal at any occupancy.
- buffer_full_o = (DEPTH - count) < 2, combinational from registered count. A push is never accepted when fewer than 2 entries are free, even for a single instruction, so overflow cannot occur.
- Push uses pre-pop occupancy; entries freed by a same-cycle pop are not reusable until the next cycle.
- Flush: next cycle head, tail and count = 0. Same-cycle fetch input is dropped and same-cycle pop is void. Flush takes priority over push/pop. rst has priority over flush.
- Reset asserted mid-operation clears everything on the next edge regardless of other inputs.

Optional Feature:
- Macro IBUF_PERF_EN.
- When defined: adds outputs perf_full_cycles_o[31:0] and perf_empty_cycles_o[31:0].
  - perf_full_cycles_o increments each cycle buffer_full_o = 1 and inst1_valid = 1 (fetch stalled).
  - perf_empty_cycles_o increments each cycle count = 0 and issue_i = 1 (decode starved).
  - Counters are cleared by rst only (not by flush) and saturate at 0xFFFFFFFF.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package / defines file: IBUF_DEPTH and IBUF_PTR_W constants, and entry type {inst, addr}. Reuses the existing InstBus / InstAddrBus widths.
- One natural sub-module, ibuf_ptr_ctrl: computes push/pop amounts, pointer and count update, and full/valid flags.
- Top level holds the storage array and output muxing.

Test Plan:
- Reset, then 8 consecutive dual pushes (addr 0x1000 upward, +4) with issue_i = 0:
  - buffer_full_o rises when count = 15 would be exceeded, i.e. asserted at count = 16.
  - Pushes stop at 16 entries; occupancy_o = 16.
- Fill with 3 instructions, then issue_i = 1, issue_mode_i = 1 for two cycles:
  - Cycle 1 presents 0x1000/0x1004, both valid, pops 2.
  - Cycle 2 presents 0x1008 with inst2_valid = 0, pops 1; buffer is then empty.
- Head at index 15, dual push plus dual pop in the same cycle: correct wrap to index 1, occupancy unchanged, data order preserved.
- Occupancy 10, flush_i = 1 together with a dual push and issue:
  - Next cycle occupancy_o = 0 and both valids = 0.
  - Pushed instructions are not visible afterwards.
- fetch_inst2_valid_i = 1 with inst1_valid = 0: no write, occupancy unchanged.
- With IBUF_PERF_EN: 5 stalled-full cycles, then 3 empty-issue cycles → counters read 5 and 3; flush leaves them unchanged, rst zeroes them.
